// File: rtl/alu_result_collector_if.sv
// Result-in / stream-out bundle for alu_result_collector.
// slave is the collector; master is the unit-plus-consumer side driving it.
interface alu_result_collector_if #(
    parameter int DATA_WIDTH = 16,
    parameter int FUNC_WIDTH = 2
);
    logic [DATA_WIDTH-1:0] In_Data;
    logic [FUNC_WIDTH-1:0] In_Func;
    logic                  In_Flag;
    logic [DATA_WIDTH-1:0] Out_Data;
    logic [FUNC_WIDTH-1:0] Out_Func;
    logic                  Out_Valid;
    logic                  Out_Ready;

    modport slave (
        input  In_Data, In_Func, In_Flag, Out_Ready,
        output Out_Data, Out_Func, Out_Valid
    );

    modport master (
        output In_Data, In_Func, In_Flag, Out_Ready,
        input  Out_Data, Out_Func, Out_Valid
    );
endinterface

// File: rtl/alu_result_collector.sv
// Captures flagged ALU results with their function tag into a small FIFO and
// presents them first-word-fall-through over a valid/ready handshake.
module alu_result_collector #(
    parameter int DATA_WIDTH = 16,
    parameter int FUNC_WIDTH = 2,
    parameter int DEPTH      = 4
) (
    input  logic                   CLK,
    input  logic                   RST,
    alu_result_collector_if.slave  bus,
    input  logic                   Clear,
    output logic [$clog2(DEPTH):0] Count,
    output logic                   Full,
    output logic                   Empty,
    output logic                   Overflow
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

    logic [FUNC_WIDTH+DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]         r_wr_ptr;
    logic [PW-1:0]         r_rd_ptr;
    logic [CW-1:0]         r_count;
    logic                  r_overflow;
    logic [DATA_WIDTH-1:0] r_out_data;
    logic [FUNC_WIDTH-1:0] r_out_func;

    logic          w_empty;
    logic          w_full;
    logic          w_pop;
    logic          w_push;
    logic          w_drop;
    logic [PW-1:0] w_rd_next;

    // Status decodes only from registered count, so In_Flag/Out_Ready never reach an output combinationally.
    assign w_empty   = (r_count == '0);
    assign w_full    = (r_count == FULL_COUNT);
    assign w_pop     = !w_empty && bus.Out_Ready;
    assign w_push    = bus.In_Flag && (!w_full || w_pop);
    assign w_drop    = bus.In_Flag && w_full && !w_pop;
    assign w_rd_next = r_rd_ptr + 1'b1;

    // NOTE: the storage array has no reset; validity is tracked by pointers and count alone.
    always_ff @(posedge CLK) begin
        if (w_push && !Clear && !RST) begin
            r_mem[r_wr_ptr] <= {bus.In_Func, bus.In_Data};
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else if (Clear) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= w_rd_next;
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + 1'b1;
            end else if (w_pop && !w_push) begin
                r_count <= r_count - 1'b1;
            end
            if (w_drop) begin
                r_overflow <= 1'b1;
            end
        end
    end

    // Head register: next stored entry when one remains, else the incoming word.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_out_data <= '0;
            r_out_func <= '0;
        end else if (!Clear) begin
            if (w_pop && r_count > CW'(1)) begin
                {r_out_func, r_out_data} <= r_mem[w_rd_next];
            end else if (w_push && (w_pop || w_empty)) begin
                r_out_data <= bus.In_Data;
                r_out_func <= bus.In_Func;
            end
        end
    end

    assign bus.Out_Data  = r_out_data;
    assign bus.Out_Func  = r_out_func;
    assign bus.Out_Valid = !w_empty;
    assign Count         = r_count;
    assign Full          = w_full;
    assign Empty         = w_empty;
    assign Overflow      = r_overflow;
endmodule
